key_load_ctrl: RTL and testbench
================================

# key_load_ctrl

Sequential key-programming controller for the locked c432 netlist. It receives a 32-bit key serially, checked by a trailing CRC-8, and commits it to a held key register only when the CRC matches. That register drives the netlist's 4 MUX-key inputs (p1..p4) and 28 XOR-key inputs (X_1..X_28). It sits between the on-chip key source (tamper-proof memory or test port) and the combinational locked core.

## Interface

Parameters:
- KEY_W, 32, key length in bits; bits [3:0] drive p1..p4, bits [31:4] drive X_1..X_28 (bit 4 = X_1).
- CRC_W, 8, CRC length in bits.
- CRC_POLY, 8'h07, CRC-8 polynomial; init value 8'h00, no final XOR.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a load; honoured only in IDLE or ERROR.
- abort  in  1  cancels an in-progress load.
- key_bit  in  1  serial data, MSB first: key bits 31..0, then CRC bits 7..0.
- key_valid  in  1  key_bit is valid this cycle.
- key_ready  out  1  controller accepts a bit this cycle.
- key_out  out  KEY_W  committed key, to p/X inputs of the core.
- key_locked  out  1  key committed; core is functional.
- key_err  out  1  last load failed the CRC check.
- busy  out  1  load in progress (SHIFT_KEY, SHIFT_CRC, CHECK).

## Operation

- FSM states: IDLE, SHIFT_KEY, SHIFT_CRC, CHECK, LOCKED, ERROR.
- IDLE: start → SHIFT_KEY. On that transition, clear the bit counter, shadow register and CRC register, and clear key_err.
- SHIFT_KEY: key_ready=1. A beat is key_valid && key_ready.
  - Each beat shifts key_bit into the shadow at the LSB end and advances the serial CRC: fb = crc[7]^key_bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - The 32nd beat → SHIFT_CRC, counter cleared.
- SHIFT_CRC: key_ready=1. Each beat shifts key_bit into an 8-bit received-CRC register. The 8th beat → CHECK.
- CHECK: key_ready=0, one cycle. Compare computed CRC with received CRC.
  - Match → LOCKED. The shadow is copied to key_out on the same edge and key_locked is set.
  - Mismatch → ERROR. key_err is set and the shadow is cleared.
- LOCKED: terminal until rst. start, abort and key_valid are ignored. key_out is held.
- ERROR: key_err is held. start → SHIFT_KEY (restart as from IDLE, clears key_err).
- abort in SHIFT_KEY, SHIFT_CRC or CHECK → IDLE, and the shadow is cleared. abort has priority over a same-cycle beat and over the CHECK decision. abort in IDLE, ERROR or LOCKED has no effect.
- start while busy is ignored.
- key_out is never partially updated. It changes only on the CHECK→LOCKED edge or on rst.

## Timing

- Reset values: state=IDLE, key_out=0, key_locked=0, key_err=0, busy=0, key_ready=0, all counters and registers 0. rst mid-load discards everything, and a committed key is cleared as well.
- start at cycle t → key_ready=1 from t+1.
- With key_valid held high, 40 beats occupy t+1..t+40. CHECK is at t+41, and key_locked/key_out (or key_err) are visible at t+42.
- key_valid low stalls the shift without loss. No bit is accepted when key_ready=0.
- busy is registered from state. It is 1 from t+1 through the CHECK cycle.

## Structure

- Package key_ctrl_pkg holds:
  - KEY_W, CRC_W, CRC_POLY, CRC_INIT;
  - field constants MUX_KEY_LSB=0, MUX_KEY_W=4, XOR_KEY_LSB=4, XOR_KEY_W=28;
  - the state enum.
- Sub-module crc8_serial (ports clk, rst, clr, en, din, crc) isolates the LFSR.
- The top level holds the FSM, 6-bit beat counter, shadow, received-CRC and key_out registers.

## Test plan

- Key 32'h00000000 with CRC 8'h00, key_valid always high → key_locked=1 and key_out=0 at t+42, key_err=0.
- Key 32'hFFFFFFFF with the model-computed CRC, with key_valid toggling every other cycle → locked after 40 beats, key_out=32'hFFFFFFFF, p1..p4=4'hF.
- Key 32'h00000000 with CRC 8'h01 → key_err=1, key_locked=0, key_out=0. A following start plus a correct load clears key_err and locks.
- abort after 20 key beats, then start and a full load of 32'hA5A5A5A5 with a correct CRC → key_out=32'hA5A5A5A5, with no residue from the aborted load.
- In LOCKED, apply start, abort and 40 beats of a different key → key_out unchanged, key_ready=0.
- rst asserted in LOCKED, and separately mid-SHIFT_CRC → all outputs 0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/key_load_ctrl_pkg.sv
// Shared constants and state encoding for the c432 key-load controller.
package key_ctrl_pkg;

    localparam int         KEY_W    = 32;
    localparam int         CRC_W    = 8;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    // Key field layout as seen by the locked core: p1..p4 then X_1..X_28.
    localparam int MUX_KEY_LSB = 0;
    localparam int MUX_KEY_W   = 4;
    localparam int XOR_KEY_LSB = 4;
    localparam int XOR_KEY_W   = 28;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_KEY = 3'd1,
        SHIFT_CRC = 3'd2,
        CHECK     = 3'd3,
        LOCKED    = 3'd4,
        ERROR     = 3'd5
    } state_t;

endpackage

// File: rtl/key_load_ctrl_if.sv
// Serial key source / key consumer bundle between key source and controller.
interface key_load_ctrl_if #(
    parameter int KEY_W = 32
);
    logic             start;
    logic             abort;
    logic             key_bit;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_locked;
    logic             key_err;
    logic             busy;

    modport master (
        output start, abort, key_bit, key_valid,
        input  key_ready, key_out, key_locked, key_err, busy
    );

    modport slave (
        input  start, abort, key_bit, key_valid,
        output key_ready, key_out, key_locked, key_err, busy
    );
endinterface

// File: rtl/key_load_ctrl_crc8_serial.sv
// Bit-serial CRC LFSR, MSB-first, no final XOR.
module crc8_serial #(
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
    parameter logic [CRC_W-1:0] CRC_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic fb;
    assign fb = crc[CRC_W-1] ^ din;

    // Advance one bit per enabled cycle; clr restarts a new message.
    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= CRC_INIT;
        else if (en)
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end

endmodule

// File: rtl/key_load_ctrl.sv
// Serial key loader: shifts in key + CRC-8, commits the key only on CRC match.
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int               KEY_W    = key_ctrl_pkg::KEY_W,
    parameter int               CRC_W    = key_ctrl_pkg::CRC_W,
    parameter logic [CRC_W-1:0] CRC_POLY = key_ctrl_pkg::CRC_POLY
) (
    input logic          clk,
    input logic          rst,
    key_load_ctrl_if.slave kif
);

    localparam int CNT_W = 6;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [KEY_W-1:0]   shadow;
    logic [CRC_W-1:0]   rx_crc;
    logic [CRC_W-1:0]   crc;
    logic [KEY_W-1:0]   key_q;
    logic               locked_q;
    logic               err_q;
    logic               ready_q;
    logic               busy_q;

    logic beat;
    logic start_go;
    logic crc_en;

    // A beat needs the registered ready, so nothing is taken outside the shift states.
    assign beat     = kif.key_valid && ready_q;
    assign start_go = kif.start && (state == IDLE || state == ERROR);
    // abort outranks a same-cycle beat, so the LFSR must not advance either.
    assign crc_en   = (state == SHIFT_KEY) && beat && !kif.abort;

    crc8_serial #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_W'(CRC_INIT))
    ) u_crc (
        .clk (clk),
        .rst (rst),
        .clr (start_go),
        .en  (crc_en),
        .din (kif.key_bit),
        .crc (crc)
    );

    // Load FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            rx_crc   <= '0;
            key_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (kif.start) begin
                        state   <= SHIFT_KEY;
                        cnt     <= '0;
                        shadow  <= '0;
                        rx_crc  <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT_KEY: begin
                    if (kif.abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        shadow  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (beat) begin
                        shadow <= {shadow[KEY_W-2:0], kif.key_bit};
                        if (cnt == CNT_W'(KEY_W-1)) begin
                            state <= SHIFT_CRC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                SHIFT_CRC: begin
                    if (kif.abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        shadow  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (beat) begin
                        rx_crc <= {rx_crc[CRC_W-2:0], kif.key_bit};
                        if (cnt == CNT_W'(CRC_W-1)) begin
                            state   <= CHECK;
                            cnt     <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    if (kif.abort) begin
                        state  <= IDLE;
                        shadow <= '0;
                    end else if (crc == rx_crc) begin
                        state    <= LOCKED;
                        key_q    <= shadow;
                        locked_q <= 1'b1;
                    end else begin
                        state  <= ERROR;
                        err_q  <= 1'b1;
                        shadow <= '0;
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign kif.key_ready  = ready_q;
    assign kif.key_out    = key_q;
    assign kif.key_locked = locked_q;
    assign kif.key_err    = err_q;
    assign kif.busy       = busy_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Scenario bench for key_load_ctrl with an expected-result queue.
module tb_key_load_ctrl;

    typedef struct {
        logic [31:0] key;
        logic        locked;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    key_load_ctrl_if #(.KEY_W(32)) kif();

    key_load_ctrl dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // Reference CRC-8 (poly 0x07, init 0, MSB first).
    function automatic logic [7:0] crc_model(input logic [31:0] key);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ key[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; kif.start = 1'b0; kif.abort = 1'b0;
        kif.key_valid = 1'b0; kif.key_bit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns at cycle t+1 (1ns after the edge that sampled start).
    task automatic start_load();
        @(posedge clk); #1;
        kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
    endtask

    // Offers bits MSB-first until n beats have been accepted; bounded.
    task automatic stream(input logic [39:0] bits, input bit toggle, input int n);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 400) begin
            kif.key_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            kif.key_bit   = bits[39-idx];
            @(negedge clk);
            if (kif.key_valid && kif.key_ready) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        kif.key_valid = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL stream_timeout: beats accepted=%0d required=%0d", idx, n);
        end
    endtask

    // From the CHECK cycle, move to the cycle where the result is visible.
    task automatic to_result();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got key=%h lk=%b er=%b busy=%b rdy=%b required all 0",
                     kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready);
        end
    endtask

    task automatic test_zero_key();
        exp_t e, g;
        e = '{key: 32'h0, locked: 1'b1, err: 1'b0};
        sb.push_back(e);
        start_load();
        checks++;
        if (kif.key_ready !== 1'b1 || kif.busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_t1_ready: rdy=%b busy=%b required 1 1", kif.key_ready, kif.busy);
        end
        stream({32'h0, 8'h00}, 1'b0, 40);
        @(negedge clk);
        checks++;
        if (kif.busy !== 1'b1 || kif.key_ready !== 1'b0 || kif.key_locked !== 1'b0) begin
            errors++;
            $display("FAIL zero_check_cycle: busy=%b rdy=%b lk=%b required 1 0 0",
                     kif.busy, kif.key_ready, kif.key_locked);
        end
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err ||
            kif.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_t42: key=%h lk=%b er=%b busy=%b required key=%h lk=%b er=%b busy=0",
                     kif.key_out, kif.key_locked, kif.key_err, kif.busy, g.key, g.locked, g.err);
        end
    endtask

    task automatic test_ones_toggle();
        exp_t e, g;
        do_reset();
        e = '{key: 32'hFFFF_FFFF, locked: 1'b1, err: 1'b0};
        sb.push_back(e);
        start_load();
        stream({32'hFFFF_FFFF, crc_model(32'hFFFF_FFFF)}, 1'b1, 40);
        @(negedge clk);
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err) begin
            errors++;
            $display("FAIL ones_toggle: key=%h lk=%b er=%b required key=%h lk=%b er=%b",
                     kif.key_out, kif.key_locked, kif.key_err, g.key, g.locked, g.err);
        end
        checks++;
        if (kif.key_out[3:0] !== 4'hF) begin
            errors++;
            $display("FAIL ones_mux_key: p=%h required F", kif.key_out[3:0]);
        end
    endtask

    task automatic test_bad_crc();
        exp_t e, g;
        do_reset();
        e = '{key: 32'h0, locked: 1'b0, err: 1'b1};
        sb.push_back(e);
        start_load();
        stream({32'h0, 8'h01}, 1'b0, 40);
        @(negedge clk);
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err) begin
            errors++;
            $display("FAIL bad_crc: key=%h lk=%b er=%b required key=%h lk=%b er=%b",
                     kif.key_out, kif.key_locked, kif.key_err, g.key, g.locked, g.err);
        end
        e = '{key: 32'h1234_5678, locked: 1'b1, err: 1'b0};
        sb.push_back(e);
        start_load();
        checks++;
        if (kif.key_err !== 1'b0 || kif.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: er=%b rdy=%b required 0 1", kif.key_err, kif.key_ready);
        end
        stream({32'h1234_5678, crc_model(32'h1234_5678)}, 1'b0, 40);
        @(negedge clk);
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err) begin
            errors++;
            $display("FAIL err_recover: key=%h lk=%b er=%b required key=%h lk=%b er=%b",
                     kif.key_out, kif.key_locked, kif.key_err, g.key, g.locked, g.err);
        end
    endtask

    task automatic test_abort();
        exp_t e, g;
        do_reset();
        start_load();
        stream({32'hFFFF_FFFF, 8'h00}, 1'b0, 20);
        // abort together with an offered beat: abort must win
        kif.abort = 1'b1; kif.key_valid = 1'b1; kif.key_bit = 1'b1;
        @(posedge clk); #1;
        kif.abort = 1'b0; kif.key_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (kif.busy !== 1'b0 || kif.key_ready !== 1'b0 || kif.key_out !== 32'h0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b rdy=%b key=%h required 0 0 0",
                     kif.busy, kif.key_ready, kif.key_out);
        end
        e = '{key: 32'hA5A5_A5A5, locked: 1'b1, err: 1'b0};
        sb.push_back(e);
        start_load();
        stream({32'hA5A5_A5A5, crc_model(32'hA5A5_A5A5)}, 1'b0, 40);
        @(negedge clk);
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err) begin
            errors++;
            $display("FAIL abort_reload: key=%h lk=%b er=%b required key=%h lk=%b er=%b",
                     kif.key_out, kif.key_locked, kif.key_err, g.key, g.locked, g.err);
        end
    endtask

    // Runs right after test_abort, so the controller is LOCKED with A5A5A5A5.
    task automatic test_locked_ignore();
        logic [39:0] bits;
        bit          saw_ready = 1'b0;
        bits = {32'h5A5A_5A5A, 8'h00};
        for (int i = 0; i < 40; i++) begin
            kif.start     = (i == 0);
            kif.abort     = (i == 5);
            kif.key_valid = 1'b1;
            kif.key_bit   = bits[39-i];
            @(negedge clk);
            if (kif.key_ready !== 1'b0 || kif.busy !== 1'b0) saw_ready = 1'b1;
            @(posedge clk); #1;
        end
        kif.start = 1'b0; kif.abort = 1'b0; kif.key_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (saw_ready) begin
            errors++;
            $display("FAIL locked_ready: key_ready/busy rose in LOCKED, required 0");
        end
        checks++;
        if (kif.key_out !== 32'hA5A5_A5A5 || kif.key_locked !== 1'b1 || kif.key_err !== 1'b0) begin
            errors++;
            $display("FAIL locked_hold: key=%h lk=%b er=%b required key=a5a5a5a5 lk=1 er=0",
                     kif.key_out, kif.key_locked, kif.key_err);
        end
    endtask

    task automatic test_rst();
        exp_t e, g;
        // rst while LOCKED
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready} !== 36'h0) begin
            errors++;
            $display("FAIL rst_locked: key=%h lk=%b er=%b busy=%b rdy=%b required all 0",
                     kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready);
        end
        // rst in the middle of the CRC field
        start_load();
        stream({32'hDEAD_BEEF, crc_model(32'hDEAD_BEEF)}, 1'b0, 35);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready} !== 36'h0) begin
            errors++;
            $display("FAIL rst_shift_crc: key=%h lk=%b er=%b busy=%b rdy=%b required all 0",
                     kif.key_out, kif.key_locked, kif.key_err, kif.busy, kif.key_ready);
        end
        // controller must be back in IDLE and load normally
        e = '{key: 32'h0F0F_0F0F, locked: 1'b1, err: 1'b0};
        sb.push_back(e);
        start_load();
        stream({32'h0F0F_0F0F, crc_model(32'h0F0F_0F0F)}, 1'b0, 40);
        @(negedge clk);
        to_result();
        g = sb.pop_front();
        checks++;
        if (kif.key_out !== g.key || kif.key_locked !== g.locked || kif.key_err !== g.err) begin
            errors++;
            $display("FAIL rst_reload: key=%h lk=%b er=%b required key=%h lk=%b er=%b",
                     kif.key_out, kif.key_locked, kif.key_err, g.key, g.locked, g.err);
        end
    endtask

    initial begin
        kif.start = 1'b0; kif.abort = 1'b0; kif.key_valid = 1'b0; kif.key_bit = 1'b0;
        test_reset();
        test_zero_key();
        test_ones_toggle();
        test_bad_crc();
        test_abort();
        test_locked_ignore();
        test_rst();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
